// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported unified memory between instruction
// fetch (F stage) and the load/store unit (M stage). At most one access is granted
// per cycle, read data returns one cycle after the grant, and per-requester stalls
// are produced for the hazard unit.
// Build option: define MEM_ARB_RR_EN to replace fixed data priority plus the
// MAX_WAIT starvation guard with round-robin arbitration on conflicts.
module mem_port_arbiter #(
    parameter int unsigned AW       = 32,
    parameter int unsigned DW       = 32,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    output logic [AW-1:0] mem_A,
    output logic [DW-1:0] mem_WD,
    output logic          mem_WE,
    input  logic [DW-1:0] mem_RD,
    output logic          stall_F,
    output logic          stall_M
);

    // One-hot style encoding so each valid flag is a single state bit.
    typedef enum logic [1:0] {
        PEND_NONE  = 2'b00,
        PEND_FETCH = 2'b01,
        PEND_LOAD  = 2'b10
    } pend_t;

    pend_t         r_pend;
    pend_t         w_pend_nxt;
    logic          w_if_gnt;
    logic          w_d_gnt;
    logic [DW-1:0] r_if_rdata;
    logic [DW-1:0] r_d_rdata;

`ifdef MEM_ARB_RR_EN
    typedef enum logic {
        OWN_FETCH = 1'b0,
        OWN_DATA  = 1'b1
    } owner_t;

    owner_t r_last_owner;

    // Round-robin: on conflict the requester that did not win last time goes next.
    always_comb begin
        w_if_gnt = 1'b0;
        w_d_gnt  = 1'b0;
        if (!RST) begin
            if (if_req && d_req) begin
                if (r_last_owner == OWN_FETCH) w_d_gnt  = 1'b1;
                else                           w_if_gnt = 1'b1;
            end else begin
                w_if_gnt = if_req;
                w_d_gnt  = d_req;
            end
        end
    end

    // Remember the most recent winner; idle cycles leave it unchanged.
    always_ff @(posedge CLK) begin
        if (RST)           r_last_owner <= OWN_FETCH;
        else if (w_if_gnt) r_last_owner <= OWN_FETCH;
        else if (w_d_gnt)  r_last_owner <= OWN_DATA;
    end
`else
    localparam int unsigned WCW = $clog2(MAX_WAIT + 1);

    logic [WCW-1:0] r_wait_cnt;

    // Data has priority unless fetch has already been denied MAX_WAIT cycles in a row.
    always_comb begin
        w_if_gnt = 1'b0;
        w_d_gnt  = 1'b0;
        if (!RST) begin
            if (if_req && d_req) begin
                if (r_wait_cnt == WCW'(MAX_WAIT)) w_if_gnt = 1'b1;
                else                              w_d_gnt  = 1'b1;
            end else begin
                w_if_gnt = if_req;
                w_d_gnt  = d_req;
            end
        end
    end

    // Count consecutive denied fetch cycles, saturating; any fetch grant or drop clears.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_wait_cnt <= '0;
        end else if (if_req && !w_if_gnt) begin
            if (r_wait_cnt != WCW'(MAX_WAIT)) r_wait_cnt <= r_wait_cnt + WCW'(1);
        end else begin
            r_wait_cnt <= '0;
        end
    end
`endif

    // Memory port mux; an idle cycle parks on the fetch address and never writes.
    always_comb begin
        mem_A  = if_addr;
        mem_WD = '0;
        mem_WE = 1'b0;
        if (w_d_gnt) begin
            mem_A  = d_addr;
            mem_WD = d_wdata;
            mem_WE = d_we;
        end
    end

    // Response state register.
    always_ff @(posedge CLK) begin
        if (RST) r_pend <= PEND_NONE;
        else     r_pend <= w_pend_nxt;
    end

    // Response next state: which requester owns the data returning next cycle.
    always_comb begin
        w_pend_nxt = PEND_NONE;
        if (w_if_gnt)            w_pend_nxt = PEND_FETCH;
        else if (w_d_gnt && !d_we) w_pend_nxt = PEND_LOAD;
    end

    // Capture read data for the granted reader; stores leave both registers untouched.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_if_rdata <= '0;
            r_d_rdata  <= '0;
        end else begin
            if (w_if_gnt)             r_if_rdata <= mem_RD;
            if (w_d_gnt && !d_we)     r_d_rdata  <= mem_RD;
        end
    end

    // A response still in flight when reset arrives is discarded immediately.
    assign if_rvalid = r_pend[0] && !RST;
    assign d_rvalid  = r_pend[1] && !RST;
    assign if_rdata  = r_if_rdata;
    assign d_rdata   = r_d_rdata;
    assign if_gnt    = w_if_gnt;
    assign d_gnt     = w_d_gnt;
    assign stall_F   = if_req && !w_if_gnt;
    assign stall_M   = d_req && !w_d_gnt;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural single-port memory:
// writes on posedge, RD refreshed on negedge from the current address.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, d_req, d_we;
    logic [31:0] if_addr, d_addr, d_wdata;
    logic        if_gnt, if_rvalid, d_gnt, d_rvalid, mem_we, stall_f, stall_m;
    logic [31:0] if_rdata, d_rdata, mem_a, mem_wd, mem_rd;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [31:0] FA0 = 32'h0040_0000;
    localparam logic [31:0] FA1 = 32'h0040_0004;
    localparam logic [31:0] DL  = 32'h7FFF_FFFC;
    localparam logic [31:0] DS  = 32'h7FFF_FFF8;
    localparam logic [31:0] DB  = 32'hDEAD_BEEF;
    localparam logic [31:0] W0  = 32'h2008_0005;
    localparam logic [31:0] W1  = 32'h0000_0013;
    localparam logic [31:0] W2  = 32'h1234_5678;
    localparam logic [31:0] Z   = 32'h0000_0000;

    mem_port_arbiter #(.AW(32), .DW(32), .MAX_WAIT(4)) dut (
        .CLK(clk), .RST(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_A(mem_a), .mem_WD(mem_wd), .mem_WE(mem_we), .mem_RD(mem_rd),
        .stall_F(stall_f), .stall_M(stall_m)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [logic [31:0]];

    always @(posedge clk) if (mem_we) mem[mem_a] = mem_wd;
    always @(negedge clk) mem_rd = mem.exists(mem_a) ? mem[mem_a] : 32'h0;

    typedef struct {
        logic        rst, ifr;
        logic [31:0] ifa;
        logic        dr, dwe;
        logic [31:0] da, dwd;
        logic        eig, edg, ewe, esf, esm, eirv, edrv;
        logic [31:0] ea, ewd, eird, edrd;
    } vec_t;

    vec_t vecs [18];

    function automatic vec_t mk(input logic r, input logic ifr, input logic [31:0] ifa,
                                input logic dr, input logic dwe, input logic [31:0] da,
                                input logic [31:0] dwd, input logic eig, input logic edg,
                                input logic ewe, input logic esf, input logic esm,
                                input logic eirv, input logic edrv, input logic [31:0] ea,
                                input logic [31:0] ewd, input logic [31:0] eird,
                                input logic [31:0] edrd);
        vec_t v;
        v.rst = r;   v.ifr = ifr; v.ifa = ifa; v.dr = dr; v.dwe = dwe; v.da = da; v.dwd = dwd;
        v.eig = eig; v.edg = edg; v.ewe = ewe; v.esf = esf; v.esm = esm;
        v.eirv = eirv; v.edrv = edrv; v.ea = ea; v.ewd = ewd; v.eird = eird; v.edrd = edrd;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    // One cycle: drive just after posedge, leave time to settle before sampling.
    task automatic cyc(input logic r, input logic ifr, input logic [31:0] ifa, input logic dr,
                       input logic dwe, input logic [31:0] da, input logic [31:0] dwd);
        @(posedge clk);
        #1;
        rst = r; if_req = ifr; if_addr = ifa; d_req = dr; d_we = dwe; d_addr = da; d_wdata = dwd;
        #3;
    endtask

    initial begin
        rst = 1'b1; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        if_addr = FA0; d_addr = Z; d_wdata = Z;
        mem[FA0] = W0; mem[FA1] = W1; mem[DL] = W2;
        repeat (2) @(posedge clk);

`ifndef MEM_ARB_RR_EN
        for (int i = 0; i < 3; i++)
            vecs[i] = mk(1, 1, FA0, 1, 1, DS, 32'hBAD0_BAD0, 0, 0, 0, 1, 1, 0, 0, FA0, Z, Z, Z);
        vecs[3]  = mk(0, 1, FA0, 0, 0, DL, Z,  1, 0, 0, 0, 0, 0, 0, FA0, Z,  Z,  Z);
        vecs[4]  = mk(0, 0, FA0, 0, 0, DL, Z,  0, 0, 0, 0, 0, 1, 0, FA0, Z,  W0, Z);
        vecs[5]  = mk(0, 1, FA1, 1, 0, DL, Z,  0, 1, 0, 1, 0, 0, 0, DL,  Z,  W0, Z);
        for (int i = 6; i < 9; i++)
            vecs[i] = mk(0, 1, FA1, 1, 0, DL, Z, 0, 1, 0, 1, 0, 0, 1, DL, Z, W0, W2);
        vecs[9]  = mk(0, 1, FA1, 1, 0, DL, Z,  1, 0, 0, 0, 1, 0, 1, FA1, Z,  W0, W2);
        vecs[10] = mk(0, 1, FA1, 1, 0, DL, Z,  0, 1, 0, 1, 0, 1, 0, DL,  Z,  W1, W2);
        vecs[11] = mk(0, 0, FA1, 1, 1, DS, DB, 0, 1, 1, 0, 0, 0, 1, DS,  DB, W1, W2);
        vecs[12] = mk(0, 0, FA1, 1, 0, DS, DB, 0, 1, 0, 0, 0, 0, 0, DS,  DB, W1, W2);
        vecs[13] = mk(0, 0, FA1, 0, 0, DS, Z,  0, 0, 0, 0, 0, 0, 1, FA1, Z,  W1, DB);
        vecs[14] = mk(0, 1, FA0, 1, 0, DL, Z,  0, 1, 0, 1, 0, 0, 0, DL,  Z,  W1, DB);
        vecs[15] = mk(0, 0, FA0, 1, 0, DL, Z,  0, 1, 0, 0, 0, 0, 1, DL,  Z,  W1, W2);
        vecs[16] = mk(0, 1, FA0, 1, 0, DL, Z,  0, 1, 0, 1, 0, 0, 1, DL,  Z,  W1, W2);
        vecs[17] = mk(0, 0, FA0, 0, 0, DL, Z,  0, 0, 0, 0, 0, 0, 1, FA0, Z,  W1, W2);

        foreach (vecs[i]) begin
            cyc(vecs[i].rst, vecs[i].ifr, vecs[i].ifa, vecs[i].dr, vecs[i].dwe,
                vecs[i].da, vecs[i].dwd);
            chk($sformatf("row%0d if_gnt", i),    32'(if_gnt),    32'(vecs[i].eig));
            chk($sformatf("row%0d d_gnt", i),     32'(d_gnt),     32'(vecs[i].edg));
            chk($sformatf("row%0d mem_WE", i),    32'(mem_we),    32'(vecs[i].ewe));
            chk($sformatf("row%0d stall_F", i),   32'(stall_f),   32'(vecs[i].esf));
            chk($sformatf("row%0d stall_M", i),   32'(stall_m),   32'(vecs[i].esm));
            chk($sformatf("row%0d if_rvalid", i), 32'(if_rvalid), 32'(vecs[i].eirv));
            chk($sformatf("row%0d d_rvalid", i),  32'(d_rvalid),  32'(vecs[i].edrv));
            chk($sformatf("row%0d mem_A", i),     mem_a,          vecs[i].ea);
            chk($sformatf("row%0d mem_WD", i),    mem_wd,         vecs[i].ewd);
            chk($sformatf("row%0d if_rdata", i),  if_rdata,       vecs[i].eird);
            chk($sformatf("row%0d d_rdata", i),   d_rdata,        vecs[i].edrd);
        end
`else
        mem[DS] = DB;
        cyc(1, 1, FA0, 1, 0, DL, Z);
        chk("rr reset if_gnt", 32'(if_gnt), 32'(1'b0));
        chk("rr reset d_gnt",  32'(d_gnt),  32'(1'b0));
        for (int i = 0; i < 6; i++) begin
            cyc(0, 1, FA0, 1, 0, DL, Z);
            chk($sformatf("rr%0d d_gnt", i),  32'(d_gnt),  32'((i % 2) == 0));
            chk($sformatf("rr%0d if_gnt", i), 32'(if_gnt), 32'((i % 2) == 1));
        end
        cyc(0, 0, FA0, 0, 0, DL, Z);
`endif

        // Load granted, reset the very next cycle: response must be discarded.
        cyc(0, 0, FA0, 1, 0, DS, Z);
        chk("rst_mid d_gnt", 32'(d_gnt), 32'(1'b1));
        cyc(1, 0, FA0, 0, 0, DS, Z);
        chk("rst_mid d_rvalid in rst", 32'(d_rvalid), 32'(1'b0));
        cyc(0, 0, FA0, 0, 0, DS, Z);
        chk("rst_mid d_rvalid after", 32'(d_rvalid), 32'(1'b0));
        chk("rst_mid d_rdata", d_rdata, Z);
        chk("rst_mid if_rdata", if_rdata, Z);

        // Store presented while reset is high must not reach memory.
        cyc(1, 0, FA0, 1, 1, DS, 32'h5555_AAAA);
        chk("rst_store mem_WE", 32'(mem_we), 32'(1'b0));
        chk("rst_store stall_M", 32'(stall_m), 32'(1'b1));
        cyc(0, 0, FA0, 1, 0, DS, Z);
        chk("rst_store load d_gnt", 32'(d_gnt), 32'(1'b1));
        cyc(0, 0, FA0, 0, 0, DS, Z);
        chk("rst_store d_rvalid", 32'(d_rvalid), 32'(1'b1));
        chk("rst_store d_rdata", d_rdata, DB);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
